// File: rtl/bitonic_sort_seq.sv
// Sequential bitonic sorter: loads N words, sorts them in place with one
// compare-exchange per cycle, then streams them out in order.
module bitonic_sort_seq #(
  parameter int LOG_N   = 3,
  parameter int W       = 8,
  parameter int DESCEND = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int N  = 1 << LOG_N;
  localparam int SW = $clog2(LOG_N + 1);
  localparam int LW = LOG_N + 1;

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t             state;
  logic [W-1:0]       mem [N];
  logic [LOG_N-1:0]   wr_idx;
  logic [LOG_N-1:0]   rd_idx;
  logic [LOG_N-1:0]   p_cnt;
  logic [SW-1:0]      k_stage;
  logic [SW-1:0]      j_stage;

  logic [LOG_N-1:0]   lo_mask;
  logic [LOG_N-1:0]   i_idx;
  logic [LOG_N-1:0]   l_idx;
  logic [LW-1:0]      k_mask;
  logic [W-1:0]       word_i;
  logic [W-1:0]       word_l;
  logic               up;
  logic               do_swap;

  // k = 2^(k_stage+1), j = 2^j_stage; i is p with a zero inserted at bit j_stage.
  always_comb begin
    lo_mask = (LOG_N'(1) << j_stage) - LOG_N'(1);
    i_idx   = ((p_cnt & ~lo_mask) << 1) | (p_cnt & lo_mask);
    l_idx   = i_idx | (LOG_N'(1) << j_stage);
    k_mask  = LW'(2) << k_stage;
    word_i  = mem[i_idx];
    word_l  = mem[l_idx];
    up      = ((({1'b0, i_idx}) & k_mask) == '0) ^ (DESCEND != 0);
    do_swap = up ? (word_i > word_l) : (word_i < word_l);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      wr_idx    <= '0;
      rd_idx    <= '0;
      p_cnt     <= '0;
      k_stage   <= '0;
      j_stage   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            wr_idx <= wr_idx + LOG_N'(1);
            if (wr_idx == LOG_N'(N - 1)) begin
              state    <= SORT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        SORT: begin
          // Inner loop over pairs, then halve j, then double k.
          if (p_cnt == LOG_N'(N / 2 - 1)) begin
            p_cnt <= '0;
            if (j_stage == '0) begin
              if (k_stage == SW'(LOG_N - 1)) begin
                k_stage   <= '0;
                state     <= DRAIN;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
              end else begin
                k_stage <= k_stage + SW'(1);
                j_stage <= k_stage + SW'(1);
              end
            end else begin
              j_stage <= j_stage - SW'(1);
            end
          end else begin
            p_cnt <= p_cnt + LOG_N'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_idx == LOG_N'(N - 1)) begin
              rd_idx    <= '0;
              state     <= LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              rd_idx   <= rd_idx + LOG_N'(1);
              out_last <= (rd_idx == LOG_N'(N - 2));
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Register file has no reset; its contents are irrelevant until a block loads.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid && in_ready) begin
      mem[wr_idx] <= in_data;
    end else if (state == SORT && do_swap) begin
      mem[i_idx] <= word_l;
      mem[l_idx] <= word_i;
    end
  end

  assign out_data = out_valid ? mem[rd_idx] : '0;

endmodule
